pzvip_tilelink_ad_tracker: RTL and testbench
============================================

# pzvip_tilelink_ad_tracker

Passive TileLink A/D-channel transaction tracker placed beside the A and D channel monitors of the pzvip_tilelink agent. It consumes the decoded A and D channel fields of the tilelink payload types and counts beats per message. It keeps a per-source table of outstanding requests and checks every D response against the request that opened it. It drives no channel signals; outputs are beat markers, an outstanding count and sticky protocol-error flags.

## Interface
Parameters:
- DATA_WIDTH, 64, data bus width in bits; power of two, at least 8.
- SIZE_WIDTH, 3, width of a_size/d_size (log2 bytes).
- SOURCE_WIDTH, 4, width of source ID; the table has 2**SOURCE_WIDTH entries.

Ports (clock and reset are one clock domain; reset is asynchronous, active-low):
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_a_valid / i_a_ready  input  1 each  A handshake; a beat transfers when both are high.
- i_a_opcode  input  3  A opcode (0 PutFull … 7 AcquirePerm)
- i_a_size  input  SIZE_WIDTH  A size
- i_a_source  input  SOURCE_WIDTH  A source
- i_d_valid / i_d_ready  input  1 each  D handshake
- i_d_opcode  input  3  D opcode (0 AccessAck, 1 AccessAckData, 2 HintAck, 4 Grant, 5 GrantData, 6 ReleaseAck)
- i_d_size  input  SIZE_WIDTH  D size
- i_d_source  input  SOURCE_WIDTH  D source
- o_a_first, o_a_last  output  1 each  combinational; current A beat is the first/last beat of its message.
- o_d_first, o_d_last  output  1 each  same, for D.
- o_outstanding  output  SOURCE_WIDTH+1  number of valid table entries.
- o_error  output  5  sticky error flags: [0] duplicate source, [1] unexpected D, [2] opcode mismatch, [3] size mismatch, [4] illegal opcode.
- o_error_pulse  output  1  high for one cycle after any cycle that sets one or more error bits.

## Operation
- Beats per message: if the opcode carries data, beats = max(1, 2**size / (DATA_WIDTH/8)). Otherwise beats = 1.
  - A opcodes 0–3 carry data; D opcodes 1 and 5 carry data.
- Per-channel beat counter:
  - Zero means the next beat is first.
  - On each handshake: if last, the counter returns to 0; otherwise it increments.
  - Last = (counter == beats-1), using opcode and size sampled on the current beat.
- A first-beat handshake:
  - If table[source] is valid, set error[0]; the entry is left unchanged.
  - Otherwise, allocate the entry with the expected D class and the request size.
  - Expected D class by A opcode: Put 0/1 → AccessAck; 2/3/4 → AccessAckData; 5 → HintAck; 6/7 → Grant or GrantData.
- D first-beat handshake:
  - If the source is not valid, set error[1].
  - Otherwise, compare the D opcode with the expected class; a mismatch sets error[2].
  - Compare the D size with the stored size; a mismatch sets error[3].
  - ReleaseAck (6) is not tracked; it is ignored entirely.
- D last-beat handshake on a valid source frees the entry, including when the same beat raised error[2] or error[3].
- Opcode 3 on D, and opcode 7 on D, set error[4]; such beats are otherwise ignored.
- Simultaneous events, same cycle, same source:
  - D last-beat release plus A first-beat allocate: release wins first; the allocation succeeds with no error.
  - A first-beat allocate plus D first beat: the D lookup sees the new allocation (bypass), so no error[1].
- o_outstanding = popcount of the valid bits; it is kept as a registered counter updated by ±1 per event, with a net 0 change when an allocate and a release happen in the same cycle.

## Timing
- Reset values:
  - table valid bits 0
  - beat counters 0
  - o_outstanding 0
  - o_error 0
  - o_error_pulse 0
- o_a_first/last and o_d_first/last are combinational from the counter and the current inputs. They are valid whenever valid is high, independent of ready.
- Table, counters, o_outstanding, o_error and o_error_pulse update on the rising i_clk edge after the handshake: latency 1.
- Valid without ready changes no state.
- Reset asserted mid-message aborts everything asynchronously: all state clears and the next beat is treated as a first beat.
- o_error bits clear only on reset.

## Configuration
- PZVIP_TILELINK_AD_TRACKER_TL_C_EN defined:
  - A opcodes 6/7 and D opcodes 4/5 are legal.
  - Grant/GrantData close Acquire entries.
- Macro undefined (TL-UL/UH only):
  - A opcodes 6/7 and D opcodes 4/5 set error[4]. The beat is counted as a single beat, with no table effect.
  - The expected-class store shrinks to 2 bits.

## Test plan
- DATA_WIDTH=64: Get (a_opcode=4, size=5, source=3) then AccessAckData size=5 source=3 × 4 beats → d_first on beat 0 only, d_last on beat 3; o_outstanding 0→1→0; o_error=0.
- PutFull size=4 source=1: A beats 2 with a_last on the 2nd, then AccessAck 1 beat → o_error=0, o_outstanding returns to 0.
- Two Gets on source 2 with no response between them → error[0]=1 and o_error_pulse high for one cycle; o_outstanding stays 1.
- AccessAck on source 5 with nothing outstanding → error[1]=1. Separately, Get size=3 answered by AccessAckData size=4 → error[3]=1.
- Same cycle: D last beat freeing source 7 plus A Get on source 7 → no error, o_outstanding unchanged.
- Without TL_C_EN, AcquireBlock (a_opcode=6) → error[4]=1. With TL_C_EN, AcquireBlock size=6 then GrantData 8 beats → clean.

Source files
------------

// File: rtl/pzvip_tilelink_ad_tracker.sv
`timescale 1ns/1ps
// pzvip_tilelink_ad_tracker
// Passive TileLink A/D tracker. Counts beats per message on both channels,
// keeps a per-source table of outstanding requests and checks every D
// response against the request that opened it. Drives no channel signals.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_a_valid/ready/opcode/size/source   observed A channel
//   i_d_valid/ready/opcode/size/source   observed D channel
//   o_a_first/o_a_last         current A beat is first/last of its message (comb)
//   o_d_first/o_d_last         same for D
//   o_outstanding              number of valid table entries
//   o_error[4:0]               sticky: dup source, unexpected D, opcode
//                              mismatch, size mismatch, illegal opcode
//   o_error_pulse              one cycle after any cycle that set an error
//
// Build option: PZVIP_TILELINK_AD_TRACKER_TL_C_EN enables TL-C
// Acquire (A 6/7) and Grant/GrantData (D 4/5); otherwise they are illegal.
module pzvip_tilelink_ad_tracker #(
  parameter int DATA_WIDTH   = 64,
  parameter int SIZE_WIDTH   = 3,
  parameter int SOURCE_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_a_valid,
  input  logic                    i_a_ready,
  input  logic [2:0]              i_a_opcode,
  input  logic [SIZE_WIDTH-1:0]   i_a_size,
  input  logic [SOURCE_WIDTH-1:0] i_a_source,
  input  logic                    i_d_valid,
  input  logic                    i_d_ready,
  input  logic [2:0]              i_d_opcode,
  input  logic [SIZE_WIDTH-1:0]   i_d_size,
  input  logic [SOURCE_WIDTH-1:0] i_d_source,
  output logic                    o_a_first,
  output logic                    o_a_last,
  output logic                    o_d_first,
  output logic                    o_d_last,
  output logic [SOURCE_WIDTH:0]   o_outstanding,
  output logic [4:0]              o_error,
  output logic                    o_error_pulse
);
  localparam int NSRC    = 2**SOURCE_WIDTH;
  localparam int BEAT_LG = $clog2(DATA_WIDTH/8);
  localparam int CNT_W   = 2**SIZE_WIDTH;  // holds up to 2**(2**SIZE_WIDTH-1) beats
  localparam int OW      = SOURCE_WIDTH+1;
`ifdef PZVIP_TILELINK_AD_TRACKER_TL_C_EN
  localparam logic TLC   = 1'b1;
  localparam int   CLS_W = 3;
`else
  localparam logic TLC   = 1'b0;
  localparam int   CLS_W = 2;
`endif
  localparam logic [CNT_W-1:0] ONE = 1;

  // Index of the last beat: 0 unless the message carries more bytes than one beat.
  function automatic logic [CNT_W-1:0] last_idx(logic data, logic [SIZE_WIDTH-1:0] size);
    int sh;
    sh = int'(size) - BEAT_LG;
    if (data && sh > 0) return (ONE << sh) - ONE;
    return '0;
  endfunction

  // Expected D class, stored as the D opcode it must match (Grant class = 4).
  function automatic logic [CLS_W-1:0] exp_cls(logic [2:0] op);
    logic [CLS_W-1:0] c;
    c = '0;
    case (op)
      3'd2, 3'd3, 3'd4: c = CLS_W'(1);
      3'd5:             c = CLS_W'(2);
`ifdef PZVIP_TILELINK_AD_TRACKER_TL_C_EN
      3'd6, 3'd7:       c = CLS_W'(4);
`endif
      default:          c = '0;
    endcase
    return c;
  endfunction

  function automatic logic cls_ok(logic [CLS_W-1:0] cls, logic [2:0] op);
`ifdef PZVIP_TILELINK_AD_TRACKER_TL_C_EN
    if (cls == CLS_W'(4)) return (op == 3'd4) || (op == 3'd5);
`endif
    return op == 3'(cls);
  endfunction

  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  logic [NSRC-1:0] vld_q, vld_d;
  logic [NSRC-1:0][CLS_W-1:0] cls_q, cls_d;
  logic [NSRC-1:0][SIZE_WIDTH-1:0] size_q, size_d;
  logic [OW-1:0] out_q, out_d;
  logic [4:0] err_q, err_set;
  logic pulse_q;

  logic a_fire, a_legal, a_data, d_fire, d_legal, d_data, d_trk;
  logic d_old_v, d_rel_old, a_dup, a_try, a_alloc, byp, d_v, d_rel;
  logic [CLS_W-1:0] a_cls, d_cls;
  logic [SIZE_WIDTH-1:0] d_sz;

  assign a_fire  = i_a_valid & i_a_ready;
  assign a_legal = (i_a_opcode < 3'd6) | TLC;
  assign a_data  = a_legal & (i_a_opcode <= 3'd3);
  assign d_fire  = i_d_valid & i_d_ready;
  assign d_legal = (i_d_opcode == 3'd0) | (i_d_opcode == 3'd1) | (i_d_opcode == 3'd2) |
                   (i_d_opcode == 3'd6) |
                   (TLC & ((i_d_opcode == 3'd4) | (i_d_opcode == 3'd5)));
  assign d_data  = d_legal & ((i_d_opcode == 3'd1) | (i_d_opcode == 3'd5));
  assign d_trk   = d_fire & d_legal & (i_d_opcode != 3'd6);  // ReleaseAck untracked

  assign o_a_first = (a_cnt_q == '0);
  assign o_a_last  = (a_cnt_q == last_idx(a_data, i_a_size));
  assign o_d_first = (d_cnt_q == '0);
  assign o_d_last  = (d_cnt_q == last_idx(d_data, i_d_size));

  assign a_cls = exp_cls(i_a_opcode);

  // A release of an existing entry is resolved first so a same-cycle
  // allocation on that source is not a duplicate.
  assign d_old_v   = vld_q[i_d_source];
  assign d_rel_old = d_trk & o_d_last & d_old_v;
  assign a_dup     = vld_q[i_a_source] & ~(d_rel_old & (i_d_source == i_a_source));
  assign a_try     = a_fire & o_a_first & a_legal;
  assign a_alloc   = a_try & ~a_dup;
  // D lookup sees an allocation made in the same cycle on an empty slot.
  assign byp       = a_alloc & (i_a_source == i_d_source) & ~d_old_v;
  assign d_v       = d_old_v | byp;
  assign d_cls     = byp ? a_cls : cls_q[i_d_source];
  assign d_sz      = byp ? i_a_size : size_q[i_d_source];
  assign d_rel     = d_trk & o_d_last & d_v;

  always_comb begin
    err_set    = '0;
    err_set[0] = a_try & a_dup;
    err_set[1] = d_trk & o_d_first & ~d_v;
    err_set[2] = d_trk & o_d_first & d_v & ~cls_ok(d_cls, i_d_opcode);
    err_set[3] = d_trk & o_d_first & d_v & (i_d_size != d_sz);
    err_set[4] = (a_fire & ~a_legal) | (d_fire & ~d_legal);
  end

  always_comb begin
    vld_d  = vld_q;
    cls_d  = cls_q;
    size_d = size_q;
    if (d_rel) vld_d[i_d_source] = 1'b0;
    if (a_alloc) begin
      // A bypassed request closed by its own single-beat response stays free.
      if (!(byp && d_rel)) vld_d[i_a_source] = 1'b1;
      cls_d[i_a_source]  = a_cls;
      size_d[i_a_source] = i_a_size;
    end
    case ({a_alloc, d_rel})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    a_cnt_d = a_cnt_q;
    if (a_fire) a_cnt_d = o_a_last ? '0 : a_cnt_q + ONE;
    d_cnt_d = d_cnt_q;
    if (d_fire) d_cnt_d = o_d_last ? '0 : d_cnt_q + ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_cnt_q <= '0;
      d_cnt_q <= '0;
      vld_q   <= '0;
      cls_q   <= '0;
      size_q  <= '0;
      out_q   <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      a_cnt_q <= a_cnt_d;
      d_cnt_q <= d_cnt_d;
      vld_q   <= vld_d;
      cls_q   <= cls_d;
      size_q  <= size_d;
      out_q   <= out_d;
      err_q   <= err_q | err_set;
      pulse_q <= |err_set;
    end
  end

  assign o_outstanding = out_q;
  assign o_error       = err_q;
  assign o_error_pulse = pulse_q;
endmodule

// File: tb/tb_pzvip_tilelink_ad_tracker.sv
`timescale 1ns/1ps
module tb_pzvip_tilelink_ad_tracker;
  localparam int DW = 64, SW = 3, SRCW = 4, NS = 16;

  logic i_clk = 1'b0, i_rst_n;
  logic i_a_valid, i_a_ready, i_d_valid, i_d_ready;
  logic [2:0] i_a_opcode, i_d_opcode;
  logic [SW-1:0] i_a_size, i_d_size;
  logic [SRCW-1:0] i_a_source, i_d_source;
  logic o_a_first, o_a_last, o_d_first, o_d_last, o_error_pulse;
  logic [SRCW:0] o_outstanding;
  logic [4:0] o_error;

  pzvip_tilelink_ad_tracker #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW), .SOURCE_WIDTH(SRCW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_a_valid(i_a_valid), .i_a_ready(i_a_ready), .i_a_opcode(i_a_opcode),
    .i_a_size(i_a_size), .i_a_source(i_a_source),
    .i_d_valid(i_d_valid), .i_d_ready(i_d_ready), .i_d_opcode(i_d_opcode),
    .i_d_size(i_d_size), .i_d_source(i_d_source),
    .o_a_first(o_a_first), .o_a_last(o_a_last), .o_d_first(o_d_first), .o_d_last(o_d_last),
    .o_outstanding(o_outstanding), .o_error(o_error), .o_error_pulse(o_error_pulse));

  always #5 i_clk = ~i_clk;

  int n_pass = 0, n_chk = 0;
  bit chk_on = 0;
  bit s_af, s_al, s_df, s_dl;

`ifdef PZVIP_TILELINK_AD_TRACKER_TL_C_EN
  localparam bit TLC = 1;
`else
  localparam bit TLC = 0;
`endif

  task automatic check(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit a_legal(int op); return op <= 5 || TLC; endfunction
  function automatic bit d_legal(int op);
    return op == 0 || op == 1 || op == 2 || op == 6 || (TLC && (op == 4 || op == 5));
  endfunction
  function automatic int beats_of(bit is_a, int op, int size);
    bit data;
    int b;
    data = is_a ? (a_legal(op) && op <= 3) : (d_legal(op) && (op == 1 || op == 5));
    if (!data) return 1;
    b = (1 << size) / (DW/8);
    return (b < 1) ? 1 : b;
  endfunction
  function automatic bit resp_ok(int aop, int dop);
    case (aop)
      0, 1:    return dop == 0;
      2, 3, 4: return dop == 1;
      5:       return dop == 2;
      default: return dop == 4 || dop == 5;
    endcase
  endfunction
  function automatic int resp_for(int aop);
    case (aop)
      0, 1:    return 0;
      2, 3, 4: return 1;
      5:       return 2;
      default: return 4 + int'($urandom_range(0, 1));
    endcase
  endfunction

  bit mv[NS];
  int mop[NS], msz[NS];
  int m_a_idx, m_d_idx;
  logic [4:0] m_err;
  bit m_pulse;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NS; i++) mv[i] = 0;
      m_a_idx = 0; m_d_idx = 0; m_err = 0; m_pulse = 0;
    end else begin
      bit af, df, afst, alst, dfst, dlst, dtrk, rel_old, alloc, seen, rel;
      int aop, asz, asrc, dop, dsz, dsrc, sop, ssz;
      logic [4:0] e;
      af = i_a_valid && i_a_ready; df = i_d_valid && i_d_ready;
      aop = i_a_opcode; asz = i_a_size; asrc = i_a_source;
      dop = i_d_opcode; dsz = i_d_size; dsrc = i_d_source;
      afst = (m_a_idx == 0); alst = (m_a_idx == beats_of(1, aop, asz) - 1);
      dfst = (m_d_idx == 0); dlst = (m_d_idx == beats_of(0, dop, dsz) - 1);
      e = 0;
      if (af && !a_legal(aop)) e[4] = 1;
      if (df && !d_legal(dop)) e[4] = 1;
      dtrk = df && d_legal(dop) && dop != 6;
      // a response finishing an existing request frees it before A is seen
      rel_old = dtrk && dlst && mv[dsrc];
      alloc = 0;
      if (af && afst && a_legal(aop)) begin
        if (mv[asrc] && !(rel_old && dsrc == asrc)) e[0] = 1;
        else alloc = 1;
      end
      seen = 0; sop = 0; ssz = 0;
      if (mv[dsrc]) begin seen = 1; sop = mop[dsrc]; ssz = msz[dsrc]; end
      else if (alloc && asrc == dsrc) begin seen = 1; sop = aop; ssz = asz; end
      if (dtrk && dfst) begin
        if (!seen) e[1] = 1;
        else begin
          if (!resp_ok(sop, dop)) e[2] = 1;
          if (ssz != dsz) e[3] = 1;
        end
      end
      rel = dtrk && dlst && seen;
      if (rel_old) mv[dsrc] = 0;
      if (alloc) begin mv[asrc] = 1; mop[asrc] = aop; msz[asrc] = asz; end
      if (rel && !rel_old) mv[dsrc] = 0;
      m_err = m_err | e;
      m_pulse = |e;
      if (af) m_a_idx = alst ? 0 : m_a_idx + 1;
      if (df) m_d_idx = dlst ? 0 : m_d_idx + 1;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n && chk_on) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < NS; i++) cnt += mv[i];
      check("m_outstanding", o_outstanding, cnt);
      check("m_error", o_error, m_err);
      check("m_error_pulse", o_error_pulse, m_pulse);
      if (i_a_valid) begin
        check("m_a_first", o_a_first, m_a_idx == 0);
        check("m_a_last", o_a_last, m_a_idx == beats_of(1, i_a_opcode, i_a_size) - 1);
      end
      if (i_d_valid) begin
        check("m_d_first", o_d_first, m_d_idx == 0);
        check("m_d_last", o_d_last, m_d_idx == beats_of(0, i_d_opcode, i_d_size) - 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    i_a_valid = 0; i_a_ready = 1; i_a_opcode = 0; i_a_size = 0; i_a_source = 0;
    i_d_valid = 0; i_d_ready = 1; i_d_opcode = 0; i_d_size = 0; i_d_source = 0;
  endtask

  // one cycle; inputs applied at posedge+1, outputs captured at negedge
  task automatic beat(bit av, int aop, int asz, int asrc, bit dv, int dop, int dsz, int dsrc);
    i_a_valid = av; i_a_ready = 1; i_a_opcode = 3'(aop); i_a_size = SW'(asz); i_a_source = SRCW'(asrc);
    i_d_valid = dv; i_d_ready = 1; i_d_opcode = 3'(dop); i_d_size = SW'(dsz); i_d_source = SRCW'(dsrc);
    @(negedge i_clk);
    s_af = o_a_first; s_al = o_a_last; s_df = o_d_first; s_dl = o_d_last;
    @(posedge i_clk); #1;
    idle();
  endtask

  task automatic do_reset();
    i_rst_n = 0; #3; i_rst_n = 1;
  endtask

  initial begin
    idle();
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_outstanding", o_outstanding, 0);
    check("rst_error", o_error, 0);
    check("rst_pulse", o_error_pulse, 0);
    i_rst_n = 1;
    chk_on = 1;

    // Get size 5 then 4-beat AccessAckData
    beat(1, 4, 5, 3, 0, 0, 0, 0);
    check("get_a_first", s_af, 1);
    check("get_a_last", s_al, 1);
    check("get_out1", o_outstanding, 1);
    for (int b = 0; b < 4; b++) begin
      beat(0, 0, 0, 0, 1, 1, 5, 3);
      check($sformatf("aad_first%0d", b), s_df, b == 0);
      check($sformatf("aad_last%0d", b), s_dl, b == 3);
    end
    check("get_out0", o_outstanding, 0);
    check("get_err", o_error, 0);

    // PutFull size 4: two A beats, then AccessAck
    beat(1, 0, 4, 1, 0, 0, 0, 0);
    check("put_last0", s_al, 0);
    beat(1, 0, 4, 1, 0, 0, 0, 0);
    check("put_first1", s_af, 0);
    check("put_last1", s_al, 1);
    check("put_out1", o_outstanding, 1);
    beat(0, 0, 0, 0, 1, 0, 4, 1);
    check("put_out0", o_outstanding, 0);
    check("put_err", o_error, 0);

    // duplicate source
    do_reset();
    beat(1, 4, 3, 2, 0, 0, 0, 0);
    beat(1, 4, 3, 2, 0, 0, 0, 0);
    check("dup_err", o_error, 1);
    check("dup_pulse", o_error_pulse, 1);
    check("dup_out", o_outstanding, 1);
    @(posedge i_clk); #1;
    check("dup_pulse_off", o_error_pulse, 0);
    check("dup_err_sticky", o_error, 1);

    // unexpected D, then size mismatch
    do_reset();
    beat(0, 0, 0, 0, 1, 0, 3, 5);
    check("unexp_err", o_error, 2);
    do_reset();
    beat(1, 4, 3, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 1, 1, 4, 0);
    check("size_err", o_error, 8);
    check("size_last0", s_dl, 0);
    beat(0, 0, 0, 0, 1, 1, 4, 0);
    check("size_last1", s_dl, 1);
    check("size_out", o_outstanding, 0);

    // same-cycle release and re-allocate on source 7
    do_reset();
    beat(1, 4, 3, 7, 0, 0, 0, 0);
    check("same_out_pre", o_outstanding, 1);
    beat(1, 4, 3, 7, 1, 1, 3, 7);
    check("same_err", o_error, 0);
    check("same_out", o_outstanding, 1);
    beat(0, 0, 0, 0, 1, 1, 3, 7);
    check("same_out_post", o_outstanding, 0);
    check("same_err_post", o_error, 0);

    // Acquire
    do_reset();
`ifdef PZVIP_TILELINK_AD_TRACKER_TL_C_EN
    beat(1, 6, 6, 0, 0, 0, 0, 0);
    check("acq_out", o_outstanding, 1);
    for (int b = 0; b < 8; b++) begin
      beat(0, 0, 0, 0, 1, 5, 6, 0);
      check($sformatf("gd_last%0d", b), s_dl, b == 7);
    end
    check("acq_err", o_error, 0);
    check("acq_out0", o_outstanding, 0);
`else
    beat(1, 6, 6, 0, 0, 0, 0, 0);
    check("acq_last", s_al, 1);
    check("acq_err", o_error, 16);
    check("acq_out", o_outstanding, 0);
`endif

    // randomized traffic, checked each cycle by the model
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        if (m_a_idx == 0) begin
          int op;
          op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
          i_a_opcode = 3'(op);
          i_a_size   = SW'($urandom_range(0, 5));
          i_a_source = SRCW'($urandom_range(0, 3));
        end
        i_a_valid = $urandom_range(0, 1);
        i_a_ready = ($urandom_range(0, 3) != 0);
        if (m_d_idx == 0) begin
          int vq[$];
          for (int i = 0; i < NS; i++) if (mv[i]) vq.push_back(i);
          if (vq.size() > 0 && $urandom_range(0, 9) < 7) begin
            int s;
            s = vq[$urandom_range(0, vq.size() - 1)];
            i_d_source = SRCW'(s);
            i_d_opcode = 3'(resp_for(mop[s]));
            i_d_size   = SW'(msz[s]);
          end else begin
            i_d_source = SRCW'($urandom_range(0, 3));
            i_d_opcode = 3'($urandom_range(0, 7));
            i_d_size   = SW'($urandom_range(0, 5));
          end
        end
        i_d_valid = $urandom_range(0, 1);
        i_d_ready = ($urandom_range(0, 3) != 0);
        if (c == 250 && seg[0]) begin
          // asynchronous reset in the middle of traffic
          #2 i_rst_n = 0;
          #1 i_rst_n = 1;
        end
        @(posedge i_clk); #1;
      end
      idle();
      @(posedge i_clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
